// File: rtl/ol_argmax.sv
// Sequential arg-max classifier: captures NUM_OUTPUTS signed scores, scans one per cycle,
// holds class/max/margin under a valid/ack handshake. Optional top-2 margin via ARGMAX_MARGIN_EN.
module ol_argmax #(
  parameter int unsigned NUM_OUTPUTS = 10,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned FRAC_BITS   = 3
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_OUTPUTS*WIDTH-1:0]     VALUES_IN,
  input  logic [NUM_OUTPUTS-1:0]           VALIDS_IN,
  input  logic                             OVERFLOW_IN,
  output logic                             READY,
  output logic [$clog2(NUM_OUTPUTS)-1:0]   CLASS_OUT,
  output logic [WIDTH-1:0]                 MAX_OUT,
  output logic [WIDTH-1:0]                 MARGIN_OUT,
  output logic                             OVERFLOW_OUT,
  output logic                             VALID_OUT,
  input  logic                             RESULT_ACK
);

  localparam int unsigned IDX_WIDTH = $clog2(NUM_OUTPUTS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // The score format is irrelevant to ordering; only reject nonsensical configurations.
  generate
    if (NUM_OUTPUTS < 2 || FRAC_BITS > WIDTH) begin : g_param_check
      $error("ol_argmax: NUM_OUTPUTS must be >= 2 and FRAC_BITS <= WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state, state_next;
  logic [NUM_OUTPUTS-1:0]  captured;
  logic signed [WIDTH-1:0] score_q [NUM_OUTPUTS];
  logic                    ovf;
  logic [IDX_WIDTH-1:0]    idx;
  logic [IDX_WIDTH-1:0]    best_idx, best_idx_nxt;
  logic signed [WIDTH-1:0] best, best_nxt;
  logic signed [WIDTH-1:0] cur;
`ifdef ARGMAX_MARGIN_EN
  logic signed [WIDTH-1:0] second, second_nxt;
`endif

  assign READY = (state == IDLE);
  assign cur   = score_q[idx];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next state; the capture edge that completes the set moves straight to SCAN.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (&(captured | VALIDS_IN)) state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (RESULT_ACK) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Running best/second update for the lane at idx; ties keep the earlier lane.
  always_comb begin
    best_nxt     = best;
    best_idx_nxt = best_idx;
`ifdef ARGMAX_MARGIN_EN
    second_nxt   = second;
`endif
    if (idx == '0) begin
      best_nxt     = cur;
      best_idx_nxt = '0;
`ifdef ARGMAX_MARGIN_EN
      second_nxt   = MOST_NEG;
`endif
    end else if (cur > best) begin
`ifdef ARGMAX_MARGIN_EN
      second_nxt   = best;
`endif
      best_nxt     = cur;
      best_idx_nxt = idx;
    end
`ifdef ARGMAX_MARGIN_EN
    else if (cur > second) begin
      second_nxt = cur;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      captured     <= '0;
      ovf          <= 1'b0;
      idx          <= '0;
      best         <= '0;
      best_idx     <= '0;
`ifdef ARGMAX_MARGIN_EN
      second       <= '0;
`endif
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) score_q[i] <= '0;
      CLASS_OUT    <= '0;
      MAX_OUT      <= '0;
      MARGIN_OUT   <= '0;
      OVERFLOW_OUT <= 1'b0;
      VALID_OUT    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // First value on each lane wins; later valids on a captured lane are dropped.
          for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            if (VALIDS_IN[i] && !captured[i]) score_q[i] <= VALUES_IN[i*WIDTH +: WIDTH];
          end
          captured <= captured | VALIDS_IN;
          if (|VALIDS_IN) ovf <= ovf | OVERFLOW_IN;
          idx <= '0;
        end
        SCAN: begin
          best     <= best_nxt;
          best_idx <= best_idx_nxt;
`ifdef ARGMAX_MARGIN_EN
          second   <= second_nxt;
`endif
          idx      <= idx + IDX_WIDTH'(1);
          if (idx == LAST_IDX) begin
            CLASS_OUT    <= best_idx_nxt;
            MAX_OUT      <= best_nxt;
`ifdef ARGMAX_MARGIN_EN
            // best >= second, so the low WIDTH bits of the wide difference are exact.
            MARGIN_OUT   <= WIDTH'(best_nxt - second_nxt);
`endif
            OVERFLOW_OUT <= ovf;
            VALID_OUT    <= 1'b1;
          end
        end
        DONE: begin
          if (RESULT_ACK) begin
            VALID_OUT <= 1'b0;
            captured  <= '0;
            ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ol_argmax.sv
// Directed self-checking bench for ol_argmax (NUM_OUTPUTS=4, WIDTH=8).
module tb_ol_argmax;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
`ifdef ARGMAX_MARGIN_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic           CLK;
  logic           RST;
  logic [N*W-1:0] VALUES_IN;
  logic [N-1:0]   VALIDS_IN;
  logic           OVERFLOW_IN;
  logic           READY;
  logic [1:0]     CLASS_OUT;
  logic [W-1:0]   MAX_OUT;
  logic [W-1:0]   MARGIN_OUT;
  logic           OVERFLOW_OUT;
  logic           VALID_OUT;
  logic           RESULT_ACK;

  int n_vec = 0;
  int n_err = 0;

  ol_argmax #(.NUM_OUTPUTS(N), .WIDTH(W), .FRAC_BITS(3)) dut (
    .CLK(CLK), .RST(RST), .VALUES_IN(VALUES_IN), .VALIDS_IN(VALIDS_IN),
    .OVERFLOW_IN(OVERFLOW_IN), .READY(READY), .CLASS_OUT(CLASS_OUT),
    .MAX_OUT(MAX_OUT), .MARGIN_OUT(MARGIN_OUT), .OVERFLOW_OUT(OVERFLOW_OUT),
    .VALID_OUT(VALID_OUT), .RESULT_ACK(RESULT_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_all(input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] v2, input logic [7:0] v3);
    VALUES_IN = {v3, v2, v1, v0};
    VALIDS_IN = 4'hF;
    tick();
    VALIDS_IN = '0;
  endtask

  task automatic do_ack();
    RESULT_ACK = 1'b1;
    tick();
    RESULT_ACK = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #3;
    n_vec++;
    if ({READY, VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT} !== {1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b vld=%b cls=%0d max=%h mrg=%h ovf=%b, need rdy=1 vld=0 cls=0 max=00 mrg=00 ovf=0",
               READY, VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT);
    end
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] emrg;
    emrg = MEN ? 8'h06 : 8'h00;
    // Overflow with no valid lane must not set the sticky flag.
    OVERFLOW_IN = 1'b1;
    tick();
    OVERFLOW_IN = 1'b0;
    drive_all(8'h05, 8'hF0, 8'h12, 8'h0C);
    n_vec++;
    if (READY !== 1'b0) begin
      n_err++;
      $display("FAIL basic_ready_scan: got %b need 0", READY);
    end
    repeat (3) tick();
    n_vec++;
    if (VALID_OUT !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early_valid: got %b need 0", VALID_OUT);
    end
    tick();
    n_vec++;
    if ({VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT, READY} !== {1'b1, 2'd2, 8'h12, emrg, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result: vld=%b cls=%0d max=%h mrg=%h ovf=%b rdy=%b, need vld=1 cls=2 max=12 mrg=%h ovf=0 rdy=0",
               VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT, READY, emrg);
    end
    do_ack();
    n_vec++;
    if ({READY, VALID_OUT} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_ack: rdy=%b vld=%b need rdy=1 vld=0", READY, VALID_OUT);
    end
  endtask

  task automatic test_ties_negatives();
    logic [31:0] vec  [3];
    logic [1:0]  ecls [3];
    logic [7:0]  emax [3];
    logic [7:0]  emrg [3];
    vec[0] = {8'h00, 8'h01, 8'h20, 8'h20}; ecls[0] = 2'd0; emax[0] = 8'h20; emrg[0] = 8'h00;
    vec[1] = {8'h90, 8'hFE, 8'hFF, 8'h80}; ecls[1] = 2'd1; emax[1] = 8'hFF; emrg[1] = 8'h01;
    vec[2] = {8'h80, 8'h80, 8'h80, 8'h7F}; ecls[2] = 2'd0; emax[2] = 8'h7F; emrg[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      if (!MEN) emrg[k] = 8'h00;
      drive_all(vec[k][7:0], vec[k][15:8], vec[k][23:16], vec[k][31:24]);
      repeat (4) tick();
      n_vec++;
      if ({VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT} !== {1'b1, ecls[k], emax[k], emrg[k]}) begin
        n_err++;
        $display("FAIL tie_neg_%0d: vld=%b cls=%0d max=%h mrg=%h, need vld=1 cls=%0d max=%h mrg=%h",
                 k, VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, ecls[k], emax[k], emrg[k]);
      end
      do_ack();
    end
  endtask

  task automatic test_staggered();
    logic [7:0] emrg;
    emrg = MEN ? 8'h03 : 8'h00;
    VALUES_IN = {8'h00, 8'h00, 8'h00, 8'h33};
    VALIDS_IN = 4'b0001;
    OVERFLOW_IN = 1'b1;
    tick();
    // Ack while idle must not disturb the partial capture.
    VALIDS_IN = '0;
    OVERFLOW_IN = 1'b0;
    RESULT_ACK = 1'b1;
    tick();
    RESULT_ACK = 1'b0;
    n_vec++;
    if ({READY, VALID_OUT} !== 2'b10) begin
      n_err++;
      $display("FAIL stag_idle: rdy=%b vld=%b need rdy=1 vld=0", READY, VALID_OUT);
    end
    VALUES_IN = {8'h00, 8'h00, 8'h00, 8'h7F};
    VALIDS_IN = 4'b0001;
    tick();
    VALUES_IN = {8'h30, 8'h20, 8'h10, 8'h7F};
    VALIDS_IN = 4'b1110;
    tick();
    VALIDS_IN = '0;
    repeat (3) tick();
    n_vec++;
    if ({VALID_OUT, READY} !== 2'b00) begin
      n_err++;
      $display("FAIL stag_early: vld=%b rdy=%b need vld=0 rdy=0", VALID_OUT, READY);
    end
    tick();
    n_vec++;
    if ({VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT} !== {1'b1, 2'd0, 8'h33, emrg, 1'b1}) begin
      n_err++;
      $display("FAIL stag_result: vld=%b cls=%0d max=%h mrg=%h ovf=%b, need vld=1 cls=0 max=33 mrg=%h ovf=1",
               VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT, emrg);
    end
  endtask

  task automatic test_hold_ack();
    logic [7:0] emrg;
    emrg = MEN ? 8'h03 : 8'h00;
    for (int c = 0; c < 20; c++) begin
      VALUES_IN = $urandom;
      VALIDS_IN = 4'(c + 1);
      OVERFLOW_IN = c[0];
      tick();
      n_vec++;
      if ({READY, VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT} !== {1'b0, 1'b1, 2'd0, 8'h33, emrg, 1'b1}) begin
        n_err++;
        $display("FAIL hold_cycle_%0d: rdy=%b vld=%b cls=%0d max=%h mrg=%h ovf=%b, need rdy=0 vld=1 cls=0 max=33 mrg=%h ovf=1",
                 c, READY, VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT, emrg);
      end
    end
    VALUES_IN = {8'h7F, 8'h7F, 8'h7F, 8'h7F};
    VALIDS_IN = 4'hF;
    OVERFLOW_IN = 1'b0;
    do_ack();
    VALIDS_IN = '0;
    n_vec++;
    if ({READY, VALID_OUT, CLASS_OUT, MAX_OUT} !== {1'b1, 1'b0, 2'd0, 8'h33}) begin
      n_err++;
      $display("FAIL ack_release: rdy=%b vld=%b cls=%0d max=%h, need rdy=1 vld=0 cls=0 max=33",
               READY, VALID_OUT, CLASS_OUT, MAX_OUT);
    end
    tick();
    n_vec++;
    if (READY !== 1'b1) begin
      n_err++;
      $display("FAIL ack_no_capture: rdy=%b need 1", READY);
    end
  endtask

  task automatic test_reset_midscan();
    logic [7:0] emrg;
    emrg = MEN ? 8'h01 : 8'h00;
    drive_all(8'h01, 8'h02, 8'h03, 8'h04);
    tick();
    tick();
    RST = 1'b1;
    #1;
    n_vec++;
    if ({READY, VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT} !== {1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL midscan_reset: rdy=%b vld=%b cls=%0d max=%h mrg=%h ovf=%b, need rdy=1 vld=0 cls=0 max=00 mrg=00 ovf=0",
               READY, VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT);
    end
    tick();
    RST = 1'b0;
    tick();
    drive_all(8'h01, 8'h02, 8'h03, 8'h04);
    repeat (3) tick();
    n_vec++;
    if (VALID_OUT !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_early: vld=%b need 0", VALID_OUT);
    end
    tick();
    n_vec++;
    if ({VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT} !== {1'b1, 2'd3, 8'h04, emrg, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_result: vld=%b cls=%0d max=%h mrg=%h ovf=%b, need vld=1 cls=3 max=04 mrg=%h ovf=0",
               VALID_OUT, CLASS_OUT, MAX_OUT, MARGIN_OUT, OVERFLOW_OUT, emrg);
    end
    do_ack();
  endtask

  initial begin
    RST = 1'b1;
    VALUES_IN = '0;
    VALIDS_IN = '0;
    OVERFLOW_IN = 1'b0;
    RESULT_ACK = 1'b0;
    test_reset();
    test_basic();
    test_ties_negatives();
    test_staggered();
    test_hold_ack();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ol_argmax.md
# ol_argmax

Sequential arg-max classifier directly downstream of the output layer. It captures the NUM_OUTPUTS signed fixed-point scores and scans them one per cycle, then presents the winning class index, its score and, optionally, the top-2 margin. The result is held under a valid/ack handshake. It is the final decision stage of the network datapath.

## Interface
- NUM_OUTPUTS, 10, number of scores/classes; must be at least 2.
- WIDTH, 8, score width, signed two's complement.
- FRAC_BITS, 3, fractional bits of scores. Informational only; the comparison is format-independent.
- IDX_WIDTH (localparam), $clog2(NUM_OUTPUTS), class index width.

Ports:
- CLK  in  1  clock; all state is updated on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- VALUES_IN  in  NUM_OUTPUTS*WIDTH  scores; lane i at [i*WIDTH +: WIDTH].
- VALIDS_IN  in  NUM_OUTPUTS  per-lane valid.
- OVERFLOW_IN  in  1  upstream overflow indication.
- READY  out  1  high while in IDLE; block accepts lanes.
- CLASS_OUT  out  IDX_WIDTH  winning lane index.
- MAX_OUT  out  WIDTH  signed winning score.
- MARGIN_OUT  out  WIDTH  unsigned best minus second-best.
- OVERFLOW_OUT  out  1  OR of OVERFLOW_IN over the capture window.
- VALID_OUT  out  1  result valid; held until acknowledged.
- RESULT_ACK  in  1  downstream consumes the result.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset enters IDLE with all registers cleared.
- **IDLE.** READY=1.
  - Each cycle, every lane i with VALIDS_IN[i]=1 and captured[i]=0 stores its score and sets captured[i].
  - A high valid on a lane that is already captured is ignored; the first value wins.
  - The sticky ovf flag ORs in OVERFLOW_IN on every IDLE cycle in which any valid bit is high.
  - When all captured bits are set, including bits set on this same edge, go to SCAN with idx=0.
- **SCAN.** One lane per cycle, idx 0..NUM_OUTPUTS-1.
  - idx=0: best=score[0], best_idx=0, second=-2^(WIDTH-1).
  - idx>0, score>best (strict signed): second=best, best=score, best_idx=idx.
  - Otherwise, if score>second: second=score.
  - Ties keep the lower index. Equal top scores give margin 0.
  - After idx=NUM_OUTPUTS-1: register the outputs, set VALID_OUT, go to DONE.
- **DONE.** READY=0 and outputs are stable. VALIDS_IN is ignored.
  - On a RESULT_ACK=1 edge: VALID_OUT drops, captured[] and ovf are cleared, state returns to IDLE.
  - CLASS_OUT, MAX_OUT, MARGIN_OUT and OVERFLOW_OUT keep their last values until the next result.
- RESULT_ACK outside DONE is ignored.
- Margin: best-second is computed at WIDTH+1 bits. The result is always in 0..2^WIDTH-1 and is output as WIDTH unsigned bits with no saturation.
- Reset asserted mid-capture or mid-scan aborts immediately. No partial result is emitted.

## Timing
- Reset values: READY=1, VALID_OUT=0, CLASS_OUT=0, MAX_OUT=0, MARGIN_OUT=0, OVERFLOW_OUT=0.
- Let edge C be the edge that sets the last captured bit.
  - SCAN occupies edges C+1 .. C+NUM_OUTPUTS.
  - VALID_OUT is high after edge C+NUM_OUTPUTS, i.e. latency is NUM_OUTPUTS cycles.
- Ack at edge A: VALID_OUT=0 and READY=1 after A. Lanes valid in the cycle before A are not captured; capture starts on the next edge.
- Throughput: one result every NUM_OUTPUTS+2 cycles minimum (capture edge, scan, ack).
- READY is a decoded state bit with no combinational path from any input.

## Configuration
- ARGMAX_MARGIN_EN defined: the second-best register and the subtractor are built, and MARGIN_OUT is as specified.
- ARGMAX_MARGIN_EN undefined: no second-best logic is built and MARGIN_OUT is tied to 0. All other behaviour is identical.

## Test plan
Defaults: NUM_OUTPUTS=4, WIDTH=8, ARGMAX_MARGIN_EN defined; lanes listed as lane0..lane3.
- Basic: lanes {0x05,0xF0,0x12,0x0C}, all valid in one cycle -> after 4 cycles VALID_OUT=1, CLASS_OUT=2, MAX_OUT=0x12, MARGIN_OUT=0x06, OVERFLOW_OUT=0.
- Tie and negatives:
  - {0x20,0x20,0x01,0x00} -> CLASS_OUT=0, MARGIN_OUT=0.
  - {0x80,0xFF,0xFE,0x90} -> CLASS_OUT=1, MAX_OUT=0xFF, MARGIN_OUT=0x01.
  - {0x7F,0x80,0x80,0x80} -> MARGIN_OUT=0xFF.
- Staggered valids:
  - Lane0 arrives at cycle 0 with OVERFLOW_IN=1.
  - Lane0 is re-asserted at cycle 2 with a different value; it must be ignored.
  - Lanes 1-3 arrive at cycle 3.
  - Required: result uses the first lane0 value, OVERFLOW_OUT=1, VALID_OUT rises 4 cycles after cycle 3.
- Hold/ack:
  - Hold RESULT_ACK=0 for 20 cycles with new valids toggling -> outputs stable, READY=0.
  - Pulse ACK -> READY=1 next cycle, VALID_OUT=0.
- Reset mid-scan: assert RST at scan idx=2 -> all outputs return to reset values asynchronously. A new full vector then completes normally.
- Macro undefined: rerun the basic case -> CLASS_OUT=2, MAX_OUT=0x12, MARGIN_OUT=0.
